// File: rtl/trig_crossbar_ctl_pkg.sv
// Shared types and register-map constants for the trigger crossbar.
package trig_crossbar_ctl_pkg;

    typedef enum logic [1:0] {
        ModeLevel   = 2'd0,
        ModeEdge    = 2'd1,
        ModeStretch = 2'd2,
        ModeRsvd    = 2'd3
    } trig_mode_t;

    typedef struct packed {
        logic       enable;
        logic       invert;
        trig_mode_t mode;
        logic [7:0] sel;
    } trigcfg_t;

    localparam int unsigned REG_CFG      = 32'h0;
    localparam int unsigned REG_WIDTH    = 32'h4;
    localparam int unsigned REG_CNT_BASE = 32'h800;
    localparam int unsigned OUT_STRIDE   = 32'h10;

    // CFG word layout: [31] enable, [10] invert, [9:8] mode, [7:0] sel; all else reads 0.
    function automatic logic [31:0] cfg_to_word(input trigcfg_t c);
        return {c.enable, 20'd0, c.invert, c.mode, c.sel};
    endfunction

    function automatic trigcfg_t word_to_cfg(input logic [31:0] w);
        trigcfg_t c;
        c.enable = w[31];
        c.invert = w[10];
        c.mode   = trig_mode_t'(w[9:8]);
        c.sel    = w[7:0];
        return c;
    endfunction

endpackage

// File: rtl/trig_crossbar_ctl_if.sv
// APB slave bus for the trigger crossbar control registers.
interface trig_crossbar_ctl_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/trig_output_channel.sv
// One crossbar output: source mux, level/edge/stretch shaping and output register.
module trig_output_channel
    import trig_crossbar_ctl_pkg::*;
#(
    parameter int unsigned NUM_IN     = 12,
    parameter int unsigned WIDTH_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     sync,
    input  logic [NUM_IN-1:0]     rise,
    input  trigcfg_t              cfg,
    input  logic [WIDTH_BITS-1:0] width,
    input  logic                  cfg_wr,
    output logic                  trig_out
);

    logic [255:0]          sync_ext;
    logic [255:0]          rise_ext;
    logic                  sync_sel;
    logic                  rise_sel;
    logic                  core;
    logic [WIDTH_BITS-1:0] cnt_q;
    logic [WIDTH_BITS-1:0] cnt_d;
    logic                  out_q;

    // Zero-extend so an 8-bit select never indexes past the vector.
    assign sync_ext = 256'(sync);
    assign rise_ext = 256'(rise);
    assign sync_sel = sync_ext[cfg.sel];
    assign rise_sel = rise_ext[cfg.sel];

    // Stretch counter holds the cycles still to drive after the current one,
    // so the edge cycle itself counts toward the programmed width.
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_wr) begin
            cnt_d = '0;
        end else if (rise_sel && cfg.mode == ModeStretch) begin
            cnt_d = (width == '0) ? '0 : width - WIDTH_BITS'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH_BITS'(1);
        end
    end

    // Core value per shaping mode.
    always_comb begin
        core = 1'b0;
        unique case (cfg.mode)
            ModeLevel:   core = sync_sel;
            ModeEdge:    core = rise_sel;
            ModeStretch: core = rise_sel | (cnt_q != '0);
            default:     core = 1'b0;
        endcase
    end

    // Counter and registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= cfg.enable ? (core ^ cfg.invert) : 1'b0;
        end
    end

    assign trig_out = out_q;

endmodule

// File: rtl/trig_crossbar_ctl.sv
// Trigger crossbar with APB control: input synchronisers, register file and
// NUM_OUT shaping channels. Define TRIG_COUNTERS_EN to add per-input 32-bit
// rising-edge counters at 0x800 + 4*i (write clears).
module trig_crossbar_ctl
    import trig_crossbar_ctl_pkg::*;
#(
    parameter int unsigned NUM_IN     = 12,
    parameter int unsigned NUM_OUT    = 12,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned WIDTH_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    trig_crossbar_ctl_if.slave  apb,
    input  logic [NUM_IN-1:0]   trig_in,
    output logic [NUM_OUT-1:0]  trig_out,
    output logic [NUM_IN-1:0]   trig_in_led,
    output logic [NUM_OUT-1:0]  trig_out_led
);

    logic [NUM_IN-1:0]     meta_q;
    logic [NUM_IN-1:0]     sync_q;
    logic [NUM_IN-1:0]     prev_q;
    logic [NUM_IN-1:0]     rise;

    trigcfg_t              cfg_q   [NUM_OUT];
    logic [WIDTH_BITS-1:0] width_q [NUM_OUT];

    logic                  access;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           addr;
    logic [31:0]           out_idx;
    logic [31:0]           reg_off;
    logic [31:0]           rd_word;
    logic                  err;
    logic                  wr_ok;
    logic [NUM_OUT-1:0]    hit_cfg;
    logic [NUM_OUT-1:0]    hit_width;
    logic [NUM_OUT-1:0]    cfg_we;
    logic [NUM_OUT-1:0]    width_we;

`ifdef TRIG_COUNTERS_EN
    logic [31:0]           cnt_idx;
    logic [NUM_IN-1:0]     hit_cnt;
    logic [NUM_IN-1:0]     cnt_clr;
    logic [31:0]           cnt_rd [NUM_IN];
`endif

    // Two-flop synchroniser plus previous-value register for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= trig_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise        = sync_q & ~prev_q;
    assign trig_in_led = sync_q;

    assign access  = apb.psel & apb.penable;
    assign paddr   = apb.paddr;
    assign addr    = 32'(paddr);
    assign out_idx = addr >> 4;
    assign reg_off = addr & (OUT_STRIDE - 32'd1);

    // Address decode, read mux and error detection for the access phase.
    always_comb begin
        rd_word   = '0;
        err       = 1'b0;
        hit_cfg   = '0;
        hit_width = '0;
`ifdef TRIG_COUNTERS_EN
        hit_cnt   = '0;
        cnt_idx   = (addr - REG_CNT_BASE) >> 2;
`endif
        if (addr[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (addr < REG_CNT_BASE) begin
            if (out_idx >= NUM_OUT || (reg_off != REG_CFG && reg_off != REG_WIDTH)) begin
                err = 1'b1;
            end else begin
                for (int n = 0; n < NUM_OUT; n++) begin
                    if (out_idx == 32'(n)) begin
                        if (reg_off == REG_CFG) begin
                            rd_word    = cfg_to_word(cfg_q[n]);
                            hit_cfg[n] = 1'b1;
                        end else begin
                            rd_word      = 32'(width_q[n]);
                            hit_width[n] = 1'b1;
                        end
                    end
                end
                // Reject CFG writes that would select a missing input or the reserved mode.
                if (apb.pwrite && reg_off == REG_CFG &&
                    (32'(apb.pwdata[7:0]) >= NUM_IN || apb.pwdata[9:8] == 2'b11)) begin
                    err = 1'b1;
                end
            end
        end else begin
`ifdef TRIG_COUNTERS_EN
            if (cnt_idx >= NUM_IN) begin
                err = 1'b1;
            end else begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (cnt_idx == 32'(i)) begin
                        rd_word    = cnt_rd[i];
                        hit_cnt[i] = 1'b1;
                    end
                end
            end
`else
            err = 1'b1;
`endif
        end
    end

    assign wr_ok    = access & apb.pwrite & ~err;
    assign cfg_we   = hit_cfg & {NUM_OUT{wr_ok}};
    assign width_we = hit_width & {NUM_OUT{wr_ok}};

    assign apb.pready  = access;
    assign apb.pslverr = access & err;
    assign apb.prdata  = (access & ~apb.pwrite & ~err) ? rd_word : 32'd0;

    // Per-output CFG and WIDTH registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_OUT; n++) begin
                cfg_q[n]   <= '0;
                width_q[n] <= WIDTH_BITS'(1);
            end
        end else begin
            for (int n = 0; n < NUM_OUT; n++) begin
                if (cfg_we[n]) begin
                    cfg_q[n] <= word_to_cfg(apb.pwdata);
                end
                if (width_we[n]) begin
                    width_q[n] <= apb.pwdata[WIDTH_BITS-1:0];
                end
            end
        end
    end

`ifdef TRIG_COUNTERS_EN
    assign cnt_clr = hit_cnt & {NUM_IN{wr_ok}};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
        logic [31:0] cnt_q;

        // Rising-edge counter; a clear on the same cycle as an edge wins.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (cnt_clr[i]) begin
                cnt_q <= '0;
            end else if (rise[i]) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end

        assign cnt_rd[i] = cnt_q;
    end
`endif

    for (genvar n = 0; n < NUM_OUT; n++) begin : g_out
        trig_output_channel #(
            .NUM_IN     (NUM_IN),
            .WIDTH_BITS (WIDTH_BITS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .sync     (sync_q),
            .rise     (rise),
            .cfg      (cfg_q[n]),
            .width    (width_q[n]),
            .cfg_wr   (cfg_we[n]),
            .trig_out (trig_out[n])
        );
    end

    assign trig_out_led = trig_out;

endmodule

// File: tb/tb_trig_crossbar_ctl.sv
// Self-checking bench for trig_crossbar_ctl: directed register/shaping checks
// followed by randomized rounds compared against a history-based model.
module tb_trig_crossbar_ctl;

    localparam int unsigned NUM_IN     = 12;
    localparam int unsigned NUM_OUT    = 12;
    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned WIDTH_BITS = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IN-1:0]  trig_in;
    logic [NUM_OUT-1:0] trig_out;
    logic [NUM_IN-1:0]  trig_in_led;
    logic [NUM_OUT-1:0] trig_out_led;

    trig_crossbar_ctl_if #(.ADDR_WIDTH(ADDR_WIDTH)) apb_bus ();

    trig_crossbar_ctl #(
        .NUM_IN     (NUM_IN),
        .NUM_OUT    (NUM_OUT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH_BITS (WIDTH_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .apb          (apb_bus),
        .trig_in      (trig_in),
        .trig_out     (trig_out),
        .trig_in_led  (trig_in_led),
        .trig_out_led (trig_out_led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: input sampled at each clock edge, plus the programmed config.
    logic [NUM_IN-1:0] hist[$];
    int                m_sel   [NUM_OUT];
    int                m_mode  [NUM_OUT];
    int                m_width [NUM_OUT];
    bit                m_inv   [NUM_OUT];
    bit                m_en    [NUM_OUT];
    int                hi_cnt  [NUM_OUT];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apb_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
        @(negedge clk);
        apb_bus.psel    = 1'b1;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = wr;
        apb_bus.paddr   = addr[ADDR_WIDTH-1:0];
        apb_bus.pwdata  = wdata;
        #1;
        check_eq("pready_setup", 32'(apb_bus.pready), 32'd0);
        @(negedge clk);
        apb_bus.penable = 1'b1;
        #1;
        check_eq("pready_access", 32'(apb_bus.pready), 32'd1);
        rdata = apb_bus.prdata;
        err   = apb_bus.pslverr;
        @(negedge clk);
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb_access(1'b1, addr, data, rd, err);
        check_eq($sformatf("wr_err@%03h", addr), 32'(err), 32'(exp_err));
    endtask

    task automatic apb_rd_chk(input logic [31:0] addr, input logic [31:0] exp_data,
                              input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb_access(1'b0, addr, 32'd0, rd, err);
        check_eq($sformatf("rd_err@%03h", addr), 32'(err), 32'(exp_err));
        check_eq($sformatf("rd_data@%03h", addr), rd, exp_data);
    endtask

    // Expected outputs after the most recent edge k: the shaping sees the input
    // sampled two edges earlier; STRETCH is high if any edge landed in the last W cycles.
    function automatic logic [NUM_OUT-1:0] model_out();
        logic [NUM_OUT-1:0] r;
        logic               core;
        int                 k;
        int                 s;
        int                 w;
        r = '0;
        k = hist.size() - 1;
        for (int n = 0; n < NUM_OUT; n++) begin
            s    = m_sel[n];
            core = 1'b0;
            if (m_mode[n] == 0) begin
                core = hist[k-2][s];
            end else if (m_mode[n] == 1) begin
                core = hist[k-2][s] & ~hist[k-3][s];
            end else begin
                w = (m_width[n] == 0) ? 1 : m_width[n];
                for (int j = 0; j < w; j++) begin
                    if (hist[k-2-j][s] && !hist[k-3-j][s]) core = 1'b1;
                end
            end
            r[n] = m_en[n] ? (core ^ m_inv[n]) : 1'b0;
        end
        return r;
    endfunction

    task automatic step(input logic [NUM_IN-1:0] v, input bit do_check);
        @(negedge clk);
        if (do_check) begin
            check_eq("rand_trig_out", 32'(trig_out), 32'(model_out()));
            check_eq("rand_in_led", 32'(trig_in_led), 32'(hist[hist.size()-2]));
        end
        trig_in = v;
        hist.push_back(v);
    endtask

    // Drive a pulse pattern on one input for 32 cycles and count high cycles per output.
    task automatic run_pulses(input int in_bit, input logic [31:0] pulse_at);
        logic [NUM_IN-1:0] v;
        for (int n = 0; n < NUM_OUT; n++) hi_cnt[n] = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            for (int n = 0; n < NUM_OUT; n++) hi_cnt[n] += int'(trig_out[n]);
            v         = '0;
            v[in_bit] = pulse_at[c];
            trig_in   = v;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_IN-1:0] v;
        logic [31:0]       w;
        int                sel;
        int                mode;

        rst             = 1'b1;
        trig_in         = '0;
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b0;
        apb_bus.paddr   = '0;
        apb_bus.pwdata  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst_trig_out", 32'(trig_out), 32'd0);
        check_eq("rst_out_led", 32'(trig_out_led), 32'd0);
        check_eq("rst_in_led", 32'(trig_in_led), 32'd0);
        check_eq("rst_prdata", apb_bus.prdata, 32'd0);
        check_eq("rst_pslverr", 32'(apb_bus.pslverr), 32'd0);
        apb_rd_chk(32'h000, 32'h0, 1'b0);
        apb_rd_chk(32'h004, 32'h1, 1'b0);
        apb_rd_chk(32'h0B4, 32'h1, 1'b0);

        // LEVEL latency: input set before edge 1 -> output high after edge 3
        apb_wr(32'h000, 32'h8000_0003, 1'b0);
        @(negedge clk);
        trig_in[3] = 1'b1;
        @(negedge clk);
        check_eq("level_e1", 32'(trig_out[0]), 32'd0);
        check_eq("in_led_e1", 32'(trig_in_led[3]), 32'd0);
        @(negedge clk);
        check_eq("level_e2", 32'(trig_out[0]), 32'd0);
        check_eq("in_led_e2", 32'(trig_in_led[3]), 32'd1);
        @(negedge clk);
        check_eq("level_e3", 32'(trig_out[0]), 32'd1);
        check_eq("out_led_e3", 32'(trig_out_led[0]), 32'd1);
        apb_wr(32'h000, 32'h8000_0403, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("level_inv_hi_in", 32'(trig_out[0]), 32'd0);
        trig_in = '0;
        repeat (4) @(negedge clk);
        check_eq("level_inv_lo_in", 32'(trig_out[0]), 32'd1);

        // EDGE vs STRETCH on the same input
        apb_wr(32'h010, 32'h8000_0102, 1'b0);
        apb_wr(32'h020, 32'h8000_0202, 1'b0);
        apb_wr(32'h024, 32'd5, 1'b0);
        run_pulses(2, 32'h1);
        check_eq("edge_one_pulse", 32'(hi_cnt[1]), 32'd1);
        check_eq("stretch_w5", 32'(hi_cnt[2]), 32'd5);
        run_pulses(2, 32'h9);
        check_eq("edge_two_pulses", 32'(hi_cnt[1]), 32'd2);
        check_eq("stretch_retrig", 32'(hi_cnt[2]), 32'd8);
        apb_wr(32'h024, 32'd0, 1'b0);
        run_pulses(2, 32'h1);
        check_eq("stretch_w0", 32'(hi_cnt[2]), 32'd1);

        // Error responses leave registers untouched
        apb_rd_chk(32'h000, 32'h8000_0403, 1'b0);
        apb_wr(32'h000, 32'h8000_0000 | NUM_IN, 1'b1);
        apb_rd_chk(32'h000, 32'h8000_0403, 1'b0);
        apb_wr(32'h000, 32'h8000_0301, 1'b1);
        apb_rd_chk(32'h000, 32'h8000_0403, 1'b0);
        apb_wr(32'h002, 32'h8000_0001, 1'b1);
        apb_rd_chk(32'h000, 32'h8000_0403, 1'b0);
        apb_wr(NUM_OUT * 32'h10, 32'h8000_0001, 1'b1);
        apb_rd_chk(NUM_OUT * 32'h10, 32'h0, 1'b1);
        apb_rd_chk(32'h008, 32'h0, 1'b1);
        apb_wr(32'h000, 32'h7FFF_F805, 1'b0);
        apb_rd_chk(32'h000, 32'h0000_0005, 1'b0);
        apb_wr(32'h034, 32'hFFFF_1234, 1'b0);
        apb_rd_chk(32'h034, 32'h0000_1234, 1'b0);

        // Disable mid-pulse clears the stretch; re-enable shows no residue
        apb_wr(32'h040, 32'h8000_0205, 1'b0);
        apb_wr(32'h044, 32'd20, 1'b0);
        @(negedge clk);
        trig_in[5] = 1'b1;
        @(negedge clk);
        trig_in[5] = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pulse_active", 32'(trig_out[4]), 32'd1);
        apb_wr(32'h040, 32'h0000_0400, 1'b0);
        @(negedge clk);
        check_eq("disabled_out", 32'(trig_out[4]), 32'd0);
        apb_wr(32'h040, 32'h8000_0205, 1'b0);
        run_pulses(5, 32'h0);
        check_eq("no_residual", 32'(hi_cnt[4]), 32'd0);

`ifdef TRIG_COUNTERS_EN
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            trig_in[7] = 1'b1;
            @(negedge clk);
            trig_in[7] = 1'b0;
        end
        repeat (4) @(negedge clk);
        apb_rd_chk(32'h81C, 32'd10, 1'b0);
        force dut.g_cnt[7].cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.g_cnt[7].cnt_q;
        apb_rd_chk(32'h81C, 32'hFFFF_FFFF, 1'b0);
        trig_in[7] = 1'b1;
        @(negedge clk);
        trig_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        apb_rd_chk(32'h81C, 32'd0, 1'b0);
        trig_in[7] = 1'b1;
        @(negedge clk);
        trig_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        apb_rd_chk(32'h81C, 32'd1, 1'b0);
        // Edge reaches the counter on the same edge that commits the clear
        @(negedge clk);
        trig_in[7] = 1'b1;
        apb_wr(32'h81C, 32'h1234_5678, 1'b0);
        trig_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        apb_rd_chk(32'h81C, 32'd0, 1'b0);
        apb_rd_chk(32'h800 + 4 * NUM_IN, 32'd0, 1'b1);
`else
        apb_rd_chk(32'h800, 32'd0, 1'b1);
        apb_rd_chk(32'h81C, 32'd0, 1'b1);
`endif

        // Randomized rounds against the model
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            trig_in = '0;
            for (int n = 0; n < NUM_OUT; n++) begin
                sel        = int'($urandom_range(0, NUM_IN - 1));
                mode       = int'($urandom_range(0, 2));
                m_sel[n]   = sel;
                m_mode[n]  = mode;
                m_inv[n]   = bit'($urandom_range(0, 1));
                m_en[n]    = ($urandom_range(0, 3) != 0);
                m_width[n] = int'($urandom_range(0, 6));
                w = {m_en[n], 20'd0, m_inv[n], 2'(mode), 8'(sel)};
                apb_wr(32'(n) * 32'h10, w, 1'b0);
                apb_wr(32'(n) * 32'h10 + 32'h4, 32'(m_width[n]), 1'b0);
            end
            hist.delete();
            repeat (10) hist.push_back('0);
            repeat (3) step('0, 1'b0);
            v = '0;
            for (int c = 0; c < 40; c++) begin
                v = v ^ NUM_IN'($urandom & $urandom & $urandom);
                step(v, 1'b1);
            end
            step('0, 1'b1);
        end

        // Asynchronous reset during an active stretch pulse
        apb_wr(32'h040, 32'h8000_0205, 1'b0);
        apb_wr(32'h044, 32'd20, 1'b0);
        @(negedge clk);
        trig_in = '0;
        trig_in[5] = 1'b1;
        @(negedge clk);
        trig_in[5] = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pre_rst_pulse", 32'(trig_out[4]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_out", 32'(trig_out), 32'd0);
        check_eq("async_rst_led", 32'(trig_out_led), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apb_rd_chk(32'h040, 32'h0, 1'b0);
        apb_rd_chk(32'h044, 32'h1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
